// File: rtl/step_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : step_controller_if
// Purpose  : Command / status bundle between a sequencer and step_controller.
// Revision : 1.0 - initial release
// ============================================================================
interface step_controller_if #(
    parameter int NBITS = 32
);
    logic             i_cmd_valid;
    logic [1:0]       i_cmd;
    logic [NBITS-1:0] i_cmd_n;
    logic             o_cmd_ready;
    logic             i_halt;
    logic             o_step;
    logic             o_busy;
    logic             o_done;
    logic             o_halted;
    logic [NBITS-1:0] o_remaining;
    logic [NBITS-1:0] o_steps_taken;

    modport master (
        output i_cmd_valid, i_cmd, i_cmd_n, i_halt,
        input  o_cmd_ready, o_step, o_busy, o_done, o_halted,
               o_remaining, o_steps_taken
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_cmd_n, i_halt,
        output o_cmd_ready, o_step, o_busy, o_done, o_halted,
               o_remaining, o_steps_taken
    );
endinterface
`default_nettype wire

// File: rtl/step_controller.sv
`default_nettype none
// ============================================================================
// Module   : step_controller
// Purpose  : Single-step / free-run sequencer issuing datapath advance pulses.
// Revision : 1.0 - initial release
// ============================================================================
module step_controller #(
    parameter int NBITS = 32
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    step_controller_if.slave  bus
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_stepping = 2'd1;
    localparam logic [1:0] c_st_running  = 2'd2;
    localparam logic [1:0] c_st_done     = 2'd3;

    localparam logic [1:0] c_cmd_nop  = 2'b00;
    localparam logic [1:0] c_cmd_step = 2'b01;
    localparam logic [1:0] c_cmd_run  = 2'b10;
    localparam logic [1:0] c_cmd_halt = 2'b11;

    logic [1:0]       r_state;
    logic [NBITS-1:0] r_remaining;
    logic [NBITS-1:0] r_steps_taken;
    logic             r_halted;

    logic w_busy;
    logic w_step;
    logic w_ready;
    logic w_accept;

    assign w_busy   = (r_state == c_st_stepping) || (r_state == c_st_running);
    // The advance pulse is combinational so i_halt can veto it in the same cycle.
    assign w_step   = w_busy && !bus.i_halt;
    assign w_ready  = (r_state == c_st_idle) || (w_busy && (bus.i_cmd == c_cmd_halt));
    assign w_accept = bus.i_cmd_valid && w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= c_st_idle;
            r_remaining   <= '0;
            r_steps_taken <= '0;
            r_halted      <= 1'b0;
        end else begin
            if (w_step) begin
                r_steps_taken <= r_steps_taken + 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        case (bus.i_cmd)
                            c_cmd_step: begin
                                if (r_halted || (bus.i_cmd_n == '0)) begin
                                    r_state <= c_st_done;
                                end else begin
                                    r_state     <= c_st_stepping;
                                    r_remaining <= bus.i_cmd_n;
                                end
                            end
                            c_cmd_run: begin
                                r_state <= r_halted ? c_st_done : c_st_running;
                            end
                            c_cmd_halt: r_state <= c_st_done;
                            default:    r_state <= c_st_idle;
                        endcase
                    end
                end

                c_st_stepping, c_st_running: begin
                    // i_halt outranks a HALT command arriving in the same cycle.
                    if (bus.i_halt) begin
                        r_halted    <= 1'b1;
                        r_remaining <= '0;
                        r_state     <= c_st_done;
                    end else if (w_accept) begin
                        r_remaining <= '0;
                        r_state     <= c_st_done;
                    end else if (r_state == c_st_stepping) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == {{(NBITS-1){1'b0}}, 1'b1}) begin
                            r_state <= c_st_done;
                        end
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.o_cmd_ready   = w_ready;
    assign bus.o_step        = w_step;
    assign bus.o_busy        = w_busy;
    assign bus.o_done        = (r_state == c_st_done);
    assign bus.o_halted      = r_halted;
    assign bus.o_remaining   = r_remaining;
    assign bus.o_steps_taken = r_steps_taken;

endmodule
`default_nettype wire

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter NBITS, default 32: width of the step-count and steps-taken fields.
REQ-002 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_cmd_valid  input  1  command present this cycle.
REQ-005 i_cmd  input  2  command code: 00 NOP, 01 STEP, 10 RUN, 11 HALT.
REQ-006 i_cmd_n  input  NBITS  number of steps for STEP; ignored for other codes.
REQ-007 o_cmd_ready  output  1  command accepted this cycle when i_cmd_valid && o_cmd_ready.
REQ-008 i_halt  input  1  end-of-program indication from the datapath (level).
REQ-009 o_step  output  1  one-cycle datapath advance enable; drives the cycle counter step input.
REQ-010 o_busy  output  1  high in STEPPING or RUNNING.
REQ-011 o_done  output  1  one-cycle pulse when a STEP/RUN/HALT sequence completes.
REQ-012 o_halted  output  1  sticky flag: i_halt has been observed while stepping.
REQ-013 o_remaining  output  NBITS  steps still to issue in STEPPING; 0 otherwise.
REQ-014 o_steps_taken  output  NBITS  total o_step pulses since reset.

Function
REQ-015 The block SHALL implement states IDLE, STEPPING, RUNNING, DONE.
REQ-016 o_cmd_ready SHALL be 1 in IDLE; in STEPPING/RUNNING it SHALL be 1 only when i_cmd==HALT; in DONE it SHALL be 0.
REQ-017 IDLE + accepted STEP with i_cmd_n>0 and o_halted=0 SHALL load o_remaining=i_cmd_n and go to STEPPING next cycle.
REQ-018 IDLE + accepted STEP with i_cmd_n=0, or STEP/RUN with o_halted=1, SHALL go to DONE without any o_step pulse.
REQ-019 IDLE + accepted RUN with o_halted=0 SHALL go to RUNNING.
REQ-020 IDLE + accepted HALT or NOP SHALL go to DONE (HALT) or stay IDLE (NOP); a NOP SHALL never pulse o_done.
REQ-021 o_step SHALL be combinational: 1 in STEPPING or RUNNING when i_halt=0; 0 otherwise.
REQ-022 In STEPPING, each cycle with o_step=1 SHALL decrement o_remaining; the cycle where o_remaining==1 and o_step=1 SHALL transition to DONE (exactly i_cmd_n pulses total).
REQ-023 In STEPPING or RUNNING, i_halt=1 SHALL suppress o_step that cycle, set o_halted, clear o_remaining, and go to DONE.
REQ-024 In STEPPING or RUNNING, an accepted HALT command SHALL go to DONE and clear o_remaining; o_step in that same cycle still follows REQ-021 (the final pulse is issued).
REQ-025 Simultaneous i_halt=1 and HALT command: i_halt precedence; o_halted set, no pulse, DONE.
REQ-026 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-027 o_steps_taken SHALL increment by 1 on every cycle with o_step=1, wrapping from 2^NBITS-1 to 0.
REQ-028 o_halted SHALL only be cleared by reset.
REQ-029 Commands presented while o_cmd_ready=0 SHALL be ignored with no state effect.

Reset
REQ-030 With i_rst=1 at a rising edge, the block SHALL enter IDLE with o_remaining=0, o_steps_taken=0, o_halted=0; o_step=0, o_busy=0, o_done=0, o_cmd_ready=1 in the following cycle.
REQ-031 Reset SHALL take priority over any command, i_halt, or in-progress STEPPING/RUNNING, and no o_step pulse SHALL be produced in the cycle after the reset edge.

Verification
REQ-032 Reset, then STEP n=3 -> exactly 3 consecutive o_step pulses, o_remaining 3,2,1, o_done 1 cycle later, o_steps_taken=3.
REQ-033 STEP n=0 -> no o_step, o_done pulses the cycle after acceptance, o_steps_taken unchanged.
REQ-034 RUN, i_halt asserted on 6th cycle of RUNNING -> 5 pulses, o_halted=1, o_done pulse; subsequent RUN -> DONE with 0 pulses.
REQ-035 STEP n=10, HALT command on 4th pulse cycle -> 4 pulses total, o_remaining=0, o_done pulse, o_halted=0.
REQ-036 NBITS=4, 15 single-steps then one more -> o_steps_taken wraps 15->0.
REQ-037 i_rst=1 mid-RUNNING with HALT command and i_halt both asserted -> IDLE, all counters 0, o_halted=0, no o_done.
